// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared definitions for the stopwatch control block, its counter datapath and
// its bench: the run/pause/lap/clear state encoding and helpers that turn the
// clock / tick / debounce settings into cycle counts.
// -----------------------------------------------------------------------------
package stopwatch_pkg;

   // Encodings are visible on state_o, so they are fixed explicitly.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_LAP   = 2'b11
   } state_e;

   // Clock cycles per count-enable tick.
   function automatic int unsigned calc_div(input int unsigned clk_hz,
                                            input int unsigned tick_hz);
      return clk_hz / tick_hz;
   endfunction

   // Clock cycles a key must stay stable; 64-bit product so large clocks
   // times long debounce windows cannot overflow.
   function automatic int unsigned calc_db_cycles(input int unsigned clk_hz,
                                                  input int unsigned debounce_ms);
      longint unsigned prod;
      prod = (64'(clk_hz) * 64'(debounce_ms)) / 64'd1000;
      return int'(prod);
   endfunction

   // Counting states: the counters advance in RUN and in LAP.
   function automatic logic is_running(input state_e s);
      return (s == ST_RUN) || (s == ST_LAP);
   endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Brings one raw active-low push-button into the clock domain, filters bounce
// and emits a single-cycle pulse when the filtered level goes from released
// (1) to pressed (0). Releases produce no pulse.
//
// Ports:
//   clk_i      system clock
//   rst_i      asynchronous active-high reset
//   key_raw_i  raw key, active-low, asynchronous to clk_i
//   press_o    one-cycle press event (registered)
// -----------------------------------------------------------------------------
module key_debounce #(
   parameter int unsigned DB_CYCLES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic key_raw_i,
   output logic press_o
);

   // Counter only needs to reach DB_CYCLES-1: the flip happens on the edge
   // that would otherwise take it to DB_CYCLES.
   localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

   logic          sync1_q;
   logic          sync2_q;
   logic          level_q;
   logic          level_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          press_q;
   logic          press_d;

   // Debounce rule: count consecutive cycles where the synchronized key
   // disagrees with the filtered level; any agreement restarts the count.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      press_d = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = CNT_ZERO;
            // Only the released-to-pressed direction is an event.
            press_d = ~sync2_q;
         end else begin
            cnt_d   = cnt_q + CNT_ONE;
         end
      end else begin
         cnt_d = CNT_ZERO;
      end
   end

   // Synchronizer, filter state and event register; everything resets to
   // "released" so no spurious press appears after reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         cnt_q   <= CNT_ZERO;
         press_q <= 1'b0;
      end else begin
         sync1_q <= key_raw_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
// Control and sequencing for the stopwatch: debounces the start/stop and
// lap/reset keys, runs the IDLE/RUN/PAUSE/LAP machine and produces the
// centisecond count-enable, the counter clear and the display freeze.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   key0_in     raw start/stop key, active-low
//   key1_in     raw lap/reset key, active-low
//   tick_o      one-cycle count-enable every DIV running cycles
//   clear_o     one-cycle clear pulse to all counters
//   lap_hold_o  display registers frozen (LAP)
//   run_o       counting (RUN or LAP)
//   state_o     current state encoding
// -----------------------------------------------------------------------------
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned CLK_HZ      = 50_000_000,
   parameter int unsigned TICK_HZ     = 100,
   parameter int unsigned DEBOUNCE_MS = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key0_in,
   input  logic       key1_in,
   output logic       tick_o,
   output logic       clear_o,
   output logic       lap_hold_o,
   output logic       run_o,
   output logic [1:0] state_o
);

   localparam int unsigned DIV       = calc_div(CLK_HZ, TICK_HZ);
   localparam int unsigned DB_CYCLES = calc_db_cycles(CLK_HZ, DEBOUNCE_MS);
   localparam int unsigned PW        = $clog2(DIV);
   localparam logic [PW-1:0] DIV_LAST   = PW'(DIV - 1);
   localparam logic [PW-1:0] PRESC_ONE  = PW'(1'b1);
   localparam logic [PW-1:0] PRESC_ZERO = {PW{1'b0}};

   logic          key0_press;
   logic          key1_press;

   state_e        state_q;
   state_e        state_d;
   logic          clear_q;
   logic          clear_d;
   logic [PW-1:0] presc_q;
   logic [PW-1:0] presc_d;
   logic          tick_q;
   logic          tick_d;

   key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key0 (
      .clk_i     (clk),
      .rst_i     (rst),
      .key_raw_i (key0_in),
      .press_o   (key0_press)
   );

   key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key1 (
      .clk_i     (clk),
      .rst_i     (rst),
      .key_raw_i (key1_in),
      .press_o   (key1_press)
   );

   // Next state and clear request. key0 is tested first everywhere, so a
   // key1 event in the same cycle is simply dropped.
   always_comb begin
      state_d = state_q;
      clear_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (key0_press) begin
               state_d = ST_RUN;
            end else if (key1_press) begin
               state_d = ST_IDLE;
               clear_d = 1'b1;
            end else begin
               state_d = state_q;
            end
         end
         ST_RUN: begin
            if (key0_press) begin
               state_d = ST_PAUSE;
            end else if (key1_press) begin
               state_d = ST_LAP;
            end else begin
               state_d = state_q;
            end
         end
         ST_LAP: begin
            if (key0_press) begin
               state_d = ST_PAUSE;
            end else if (key1_press) begin
               state_d = ST_RUN;
            end else begin
               state_d = state_q;
            end
         end
         ST_PAUSE: begin
            if (key0_press) begin
               state_d = ST_RUN;
            end else if (key1_press) begin
               state_d = ST_IDLE;
               clear_d = 1'b1;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Prescaler advances for each cycle spent counting and holds its partial
   // value while paused. The tick is precomputed from the next-state values
   // so it can be registered yet line up with run_o and the prescaler.
   always_comb begin
      presc_d = presc_q;
      if (clear_d) begin
         presc_d = PRESC_ZERO;
      end else if (is_running(state_q)) begin
         if (presc_q == DIV_LAST) begin
            presc_d = PRESC_ZERO;
         end else begin
            presc_d = presc_q + PRESC_ONE;
         end
      end else begin
         presc_d = presc_q;
      end
      tick_d = is_running(state_d) && (presc_d == DIV_LAST);
   end

   // State, clear pulse, prescaler and tick registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         clear_q <= 1'b0;
         presc_q <= PRESC_ZERO;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         clear_q <= clear_d;
         presc_q <= presc_d;
         tick_q  <= tick_d;
      end
   end

   assign state_o    = state_q;
   assign run_o      = is_running(state_q);
   assign lap_hold_o = (state_q == ST_LAP);
   assign clear_o    = clear_q;
   assign tick_o     = tick_q;

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control and sequencing block for the stopwatch datapath. Takes two raw push-button inputs, debounces them, and runs the run/pause/lap/clear state machine. It generates the centisecond count-enable tick, the counter clear pulse and the display-freeze (lap hold) signal that drive the ms/sec/min counter chain and the 7-segment decode. It sits between the board keys and the counter datapath, replacing ad-hoc key handling.

## Interface
- `CLK_HZ`, 50_000_000, input clock frequency in Hz.
- `TICK_HZ`, 100, count-enable rate; `DIV = CLK_HZ/TICK_HZ`, must be ≥ 2.
- `DEBOUNCE_MS`, 20, stable time required on a key; `DB_CYCLES = CLK_HZ*DEBOUNCE_MS/1000`, must be ≥ 1.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `key0_in`  in  1  raw start/stop key, active-low, asynchronous to `clk`.
- `key1_in`  in  1  raw lap/reset key, active-low, asynchronous to `clk`.
- `tick_o`  out  1  one-cycle count-enable pulse to the centisecond counter.
- `clear_o`  out  1  one-cycle synchronous clear pulse to all counters.
- `lap_hold_o`  out  1  high = display registers frozen, counters keep running.
- `run_o`  out  1  high while counting (states RUN, LAP).
- `state_o`  out  2  current state encoding.

## Operation
- Each key passes through a 2-FF synchronizer, then a debounce counter.
  - The debounced level changes only after the synchronized level differs from it for `DB_CYCLES` consecutive cycles.
  - Any mismatch shorter than that resets the counter.
- A press event is a single-cycle pulse on the debounced 1→0 transition. Releases generate no event.
- FSM states: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, LAP=2'b11.
- IDLE:
  - key0 → RUN.
  - key1 → stay in IDLE and pulse `clear_o`.
- RUN:
  - key0 → PAUSE.
  - key1 → LAP.
- LAP (counting continues, display frozen):
  - key1 → RUN, releasing the hold.
  - key0 → PAUSE, releasing the hold.
- PAUSE:
  - key0 → RUN.
  - key1 → IDLE and pulse `clear_o`.
- Simultaneous key0 and key1 events in the same cycle: key0 is taken and key1 is dropped, not queued.
- Prescaler counts 0..DIV-1 only while `run_o` is high.
  - It freezes (keeps its partial count) in PAUSE.
  - It returns to 0 on `clear_o` and on reset.
  - `tick_o` = (`run_o` and prescaler == DIV-1); the prescaler wraps to 0 on the same edge.
- Outputs are decoded from registered state:
  - `run_o` = (state==RUN or state==LAP).
  - `lap_hold_o` = (state==LAP).
  - `clear_o` is a registered pulse.
- Reset values:
  - State IDLE; prescaler 0; debounce counters 0; debounced key levels 1 (released).
  - `tick_o`, `clear_o`, `lap_hold_o`, `run_o` all 0; `state_o`=2'b00.
- Reset asserted mid-operation aborts everything immediately (asynchronously). No event pending before reset survives it.

## Timing
- Raw key edge to press event: 2 sync cycles + `DB_CYCLES` cycles.
- Press event to state/`run_o`/`lap_hold_o` change: 1 cycle (registered on the next edge).
- `clear_o` is high for exactly the one cycle after the key1 event, coincident with the new state.
- First `tick_o` after entering RUN from a cleared prescaler: the DIV-th cycle with `run_o` high.
- Tick period while running: exactly DIV cycles. After PAUSE→RUN, the remaining partial period completes first.
- Two presses closer than `DB_CYCLES` apart, bounce included, produce at most one event.

## Structure
- Package `stopwatch_pkg` holds the state enum/encodings (IDLE, RUN, PAUSE, LAP) and the derived-constant helpers for `DIV` and `DB_CYCLES`, shared with the counter datapath and the bench.
- Sub-module `key_debounce` (synchronizer + counter + press-event pulse) is parameterized by `DB_CYCLES` and instantiated once per key.
- Target size: ~80 lines for `key_debounce`, ~150 lines for the top.

## Test plan
Common parameters: `CLK_HZ`=1000, `TICK_HZ`=100 (`DIV`=10), `DEBOUNCE_MS`=2 (`DB_CYCLES`=2).

- **Reset:** assert `rst` mid-RUN → same cycle `state_o`=00 and all outputs 0. After release, no tick until key0 is pressed.
- **Debounce:** key0 low for 1 cycle, repeated 5 times → no event, state stays IDLE. Then hold low for 6 cycles → `run_o` high exactly 5 cycles after the first sampled low.
- **Tick cadence:** IDLE→RUN, run 35 cycles → exactly 3 `tick_o` pulses, 10 cycles apart. Pause at prescaler=4, resume → next tick 6 running cycles later.
- **Lap:** RUN, key1 → `lap_hold_o`=1, `state_o`=11, ticks continue. Key1 again → `lap_hold_o`=0, `state_o`=01.
- **Clear:** PAUSE, key1 → one-cycle `clear_o`, `state_o`=00, prescaler 0. Key1 in IDLE → another single `clear_o` pulse.
- **Simultaneous:** key0 and key1 events in the same cycle from RUN → PAUSE, no LAP entry, no `clear_o`.
